seq_stream_checker: RTL and testbench
=====================================

# seq_stream_checker

Downstream consumer of the 8-bit sequence generator. Each valid sample on `din` is compared against the generator's fixed nine-value cycle: 3, 12, 34, 59, 233, 24, 1, 155, 0, then repeat. The block acquires phase lock on the stream, flags and counts deviations, and counts completed cycles. Its status outputs feed the board-level LEDs and the self-test logic.

## Interface
- `LOCK_N`, default 4: consecutive matching samples, the first one included, required to declare lock (range 2–15).
- `MISS_N`, default 2: consecutive mismatches while locked that drop lock (range 1–15).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset. Dominates all other inputs.
- `din`  in  8  sample from the generator's `z` output.
- `din_valid`  in  1  `din` is sampled on a cycle only when this is 1.
- `locked`  out  1  registered; 1 while in LOCK.
- `err`  out  1  registered one-cycle pulse per mismatching valid sample while in LOCK.
- `err_cnt`  out  8  registered; mismatches while in LOCK; saturates at 255.
- `cycle_cnt`  out  8  registered; completed cycles while in LOCK; wraps 255→0.
- `expected`  out  8  registered; table value the next valid sample is compared against, `TABLE[idx]`.

## Operation
- Constant table, `TABLE[0..8]` = 3, 12, 34, 59, 233, 24, 1, 155, 0.
  - All entries are unique, so any table value maps to exactly one index.
- Internal state:
  - `idx`: 4-bit, 0..8; increments 8→0.
  - `match_cnt`: 4-bit.
  - `miss_cnt`: 4-bit.
- FSM states: HUNT, CHECK, LOCK.
- HUNT
  - Valid `din` equal to `TABLE[k]`: `idx` ← (k+1) mod 9, `match_cnt` ← 1, go to CHECK.
  - Valid `din` not in the table: stay in HUNT, no counter changes.
- CHECK
  - Valid `din == TABLE[idx]`: `idx`++, `match_cnt`++. When `match_cnt` reaches `LOCK_N`, go to LOCK and clear `miss_cnt`.
  - Valid mismatch: go to HUNT with `idx` ← 0. No `err`, no `err_cnt` change.
- LOCK
  - Every valid sample advances `idx` (flywheel), whether or not it matches.
  - Match: `miss_cnt` ← 0.
  - Match with `idx == 8` (value 0): `cycle_cnt`++.
  - Mismatch: `err` = 1 for the following cycle, `err_cnt`++ (saturating), `miss_cnt`++.
  - When `miss_cnt` reaches `MISS_N`: go to HUNT, `idx` ← 0, `locked` ← 0.
- `din_valid` = 0: state, `idx` and all counters hold; `err` = 0.
- `err_cnt` and `cycle_cnt` persist across loss of lock. Only `reset` clears them.
- Unused state encodings recover to HUNT on the next edge.

## Timing
- Reset values: `locked` = 0, `err` = 0, `err_cnt` = 0, `cycle_cnt` = 0, `expected` = 3, FSM = HUNT, `idx` = 0, `match_cnt` = 0, `miss_cnt` = 0.
- Latency: every output reflects the sample taken on edge N right after edge N, i.e. one cycle.
- Lock acquisition: `locked` rises after the edge that samples the `LOCK_N`-th consecutive valid match.
- Loss of lock: `locked` falls after the edge that samples the `MISS_N`-th consecutive mismatch. `err` is 1 in that same cycle.
- Match and wrap together (sample 0 at `idx` 8 in LOCK): `cycle_cnt`++ and `idx` → 0 on the same edge.
- Reset asserted mid-operation, any state: all outputs take reset values after the next edge, regardless of `din_valid`.
- `err` is never high in two consecutive cycles unless two consecutive valid samples mismatch.

## Test plan
1. Reset, then the generator stream 3, 12, 34, 59, 233 with `din_valid` = 1 every cycle -> `locked` = 1 after the edge sampling 59, `expected` = 233, `err_cnt` = 0.
2. Lock, then run the stream through 155, 0 -> `cycle_cnt` = 1 after 0 is sampled. Continue for 256 full cycles -> `cycle_cnt` wraps to 0 (with 256 cycles counted from the first 0 sampled in LOCK).
3. Locked, expecting 233; inject 77, then resume with 24 -> `err` pulses for one cycle, `err_cnt` = 1, `locked` stays 1, `miss_cnt` is back to 0.
4. Locked, `MISS_N` = 2; inject 77, 77 -> `err` is high in both following cycles, `err_cnt` = 2, `locked` = 0. A subsequent 1, 155, 0, 3 re-locks after 3 is sampled.
5. Locked; toggle `din_valid` 1/0 with `din` = 99 on the invalid cycles -> no errors, and `idx`/`expected` advance only on valid cycles. Then force 300 mismatches -> `err_cnt` saturates at 255.
6. HUNT, feed 7, 12, 34, 200 -> 7 is ignored, 12/34 enter CHECK, 200 returns the FSM to HUNT with `err` = 0 and `err_cnt` = 0. Assert `reset` during CHECK -> all outputs at reset values after one edge.

Source files
------------

// File: rtl/seq_stream_checker_if.sv
// Sample stream and status bundle between the sequence generator side and the checker.
interface seq_stream_checker_if;
  logic [7:0] din;
  logic       din_valid;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] cycle_cnt;
  logic [7:0] expected;

  modport master (
    output din, din_valid,
    input  locked, err, err_cnt, cycle_cnt, expected
  );

  modport slave (
    input  din, din_valid,
    output locked, err, err_cnt, cycle_cnt, expected
  );
endinterface

// File: rtl/seq_stream_checker.sv
// Phase-locks onto the nine-value generator cycle, flags/counts deviations while locked
// and counts completed cycles.
module seq_stream_checker #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned MISS_N = 2
) (
  input logic                 clk,
  input logic                 reset,
  seq_stream_checker_if.slave s_io
);

  typedef enum logic [1:0] {
    StHunt  = 2'd0,
    StCheck = 2'd1,
    StLock  = 2'd2
  } state_e;

  function automatic logic [7:0] tbl_val(input logic [3:0] i);
    case (i)
      4'd0:    return 8'd3;
      4'd1:    return 8'd12;
      4'd2:    return 8'd34;
      4'd3:    return 8'd59;
      4'd4:    return 8'd233;
      4'd5:    return 8'd24;
      4'd6:    return 8'd1;
      4'd7:    return 8'd155;
      4'd8:    return 8'd0;
      default: return 8'd3;
    endcase
  endfunction

  function automatic logic [3:0] idx_inc(input logic [3:0] i);
    return (i >= 4'd8) ? 4'd0 : i + 4'd1;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic [3:0] miss_cnt_q, miss_cnt_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [7:0] cycle_cnt_q, cycle_cnt_d;
  logic [7:0] expected_q, expected_d;

  logic       hit;
  logic [3:0] hit_idx;
  logic       match;

  // Table entries are unique, so at most one index can hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (s_io.din == tbl_val(4'(k))) begin
        hit     = 1'b1;
        hit_idx = 4'(k);
      end
    end
  end

  assign match = (s_io.din == tbl_val(idx_q));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    cycle_cnt_d = cycle_cnt_q;

    case (state_q)
      StHunt: begin
        if (s_io.din_valid && hit) begin
          idx_d       = idx_inc(hit_idx);
          match_cnt_d = 4'd1;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (s_io.din_valid) begin
          if (match) begin
            idx_d       = idx_inc(idx_q);
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_d == 4'(LOCK_N)) begin
              state_d    = StLock;
              miss_cnt_d = 4'd0;
            end
          end else begin
            state_d = StHunt;
            idx_d   = 4'd0;
          end
        end
      end
      StLock: begin
        if (s_io.din_valid) begin
          idx_d = idx_inc(idx_q);
          if (match) begin
            miss_cnt_d = 4'd0;
            if (idx_q == 4'd8) cycle_cnt_d = cycle_cnt_q + 8'd1;
          end else begin
            err_d      = 1'b1;
            err_cnt_d  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_d == 4'(MISS_N)) begin
              state_d = StHunt;
              idx_d   = 4'd0;
            end
          end
        end
      end
      default: begin
        state_d = StHunt;
        idx_d   = 4'd0;
      end
    endcase

    locked_d   = (state_d == StLock);
    expected_d = tbl_val(idx_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHunt;
      idx_q       <= 4'd0;
      match_cnt_q <= 4'd0;
      miss_cnt_q  <= 4'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
      cycle_cnt_q <= 8'd0;
      expected_q  <= 8'd3;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      expected_q  <= expected_d;
    end
  end

  assign s_io.locked    = locked_q;
  assign s_io.err       = err_q;
  assign s_io.err_cnt   = err_cnt_q;
  assign s_io.cycle_cnt = cycle_cnt_q;
  assign s_io.expected  = expected_q;

endmodule

// File: tb/tb_seq_stream_checker.sv
// Randomized and directed bench for seq_stream_checker against a sample-level reference model.
module tb_seq_stream_checker;
  localparam int LockN = 4;
  localparam int MissN = 2;
  localparam int Hunt = 0, Check = 1, Lock = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_stream_checker_if sif();

  seq_stream_checker #(
    .LOCK_N(LockN),
    .MISS_N(MissN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .s_io (sif)
  );

  int total = 0;
  int bad   = 0;
  int tbl[9] = '{3, 12, 34, 59, 233, 24, 1, 155, 0};

  // Reference model: mode, next expected table position, run/miss streaks, counters.
  int m_mode, m_pos, m_run, m_miss, m_errc, m_cyc;
  bit m_err;

  logic [25:0] dut_vec;
  assign dut_vec = {sif.locked, sif.err, sif.err_cnt, sif.cycle_cnt, sif.expected};

  function automatic int find(input int d);
    for (int k = 0; k < 9; k++) if (tbl[k] == d) return k;
    return -1;
  endfunction

  function automatic logic [25:0] model_vec();
    return {m_mode == Lock, m_err, 8'(m_errc), 8'(m_cyc), 8'(tbl[m_pos])};
  endfunction

  function void model_step(input bit r, input bit v, input int d);
    int k;
    m_err = 1'b0;
    if (r) begin
      m_mode = Hunt; m_pos = 0; m_run = 0; m_miss = 0; m_errc = 0; m_cyc = 0;
    end else if (v) begin
      if (m_mode == Hunt) begin
        k = find(d);
        if (k >= 0) begin m_pos = (k + 1) % 9; m_run = 1; m_mode = Check; end
      end else if (m_mode == Check) begin
        if (d == tbl[m_pos]) begin
          m_pos = (m_pos + 1) % 9;
          m_run++;
          if (m_run == LockN) begin m_mode = Lock; m_miss = 0; end
        end else begin
          m_mode = Hunt; m_pos = 0;
        end
      end else begin
        if (d == tbl[m_pos]) begin
          if (m_pos == 8) m_cyc = (m_cyc + 1) % 256;
          m_miss = 0;
        end else begin
          m_err = 1'b1;
          m_errc = (m_errc < 255) ? m_errc + 1 : 255;
          m_miss++;
        end
        m_pos = (m_pos + 1) % 9;
        if (m_miss == MissN) begin m_mode = Hunt; m_pos = 0; end
      end
    end
  endfunction

  task automatic step(input bit r, input bit v, input logic [7:0] d);
    @(negedge clk);
    reset = r; sif.din_valid = v; sif.din = d;
    @(posedge clk);
    model_step(r, v, int'(d));
    #1;
  endtask

  function automatic logic [7:0] bad_val();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (int'(v) == tbl[m_pos]) v = v ^ 8'h01;
    return v;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      total++;
      if (dut_vec !== {1'b0, 1'b0, 8'd0, 8'd0, 8'd3}) begin
        bad++; $display("FAIL reset_values: got %h want %h", dut_vec, {1'b0, 1'b0, 8'd0, 8'd0, 8'd3});
      end
    end
  endtask

  task automatic test_lock_acquire();
    int seq[5] = '{3, 12, 34, 59, 233};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'(seq[i]));
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL lock_acquire[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
      if (i == 2) begin
        total++;
        if (sif.locked !== 1'b0) begin bad++; $display("FAIL lock_early: got %b want 0", sif.locked); end
      end
      if (i == 3) begin
        total++;
        if (sif.locked !== 1'b1 || sif.expected !== 8'd233 || sif.err_cnt !== 8'd0) begin
          bad++; $display("FAIL lock_at_59: got l=%b e=%0d ec=%0d want 1 233 0",
                          sif.locked, sif.expected, sif.err_cnt);
        end
      end
    end
  endtask

  task automatic test_cycle_wrap();
    int seq[4] = '{24, 1, 155, 0};
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(seq[i]));
    total++;
    if (sif.cycle_cnt !== 8'd1) begin
      bad++; $display("FAIL first_cycle: got %0d want 1", sif.cycle_cnt);
    end
    for (int c = 0; c < 255; c++) begin
      for (int i = 0; i < 9; i++) begin
        step(1'b0, 1'b1, 8'(tbl[i]));
        total++;
        if (dut_vec !== model_vec()) begin
          bad++; $display("FAIL cycle_run[%0d.%0d]: got %h want %h", c, i, dut_vec, model_vec());
        end
      end
    end
    total++;
    if (sif.cycle_cnt !== 8'd0 || sif.locked !== 1'b1) begin
      bad++; $display("FAIL cycle_wrap: got cc=%0d l=%b want 0 1", sif.cycle_cnt, sif.locked);
    end
  endtask

  task automatic test_single_error();
    int seq[9] = '{3, 12, 34, 59, 77, 24, 77, 155, 0};
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 8'(seq[i]));
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL single_err[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
      if (i == 4) begin
        total++;
        if (sif.err !== 1'b1 || sif.err_cnt !== 8'd1 || sif.locked !== 1'b1) begin
          bad++; $display("FAIL err_pulse: got err=%b ec=%0d l=%b want 1 1 1",
                          sif.err, sif.err_cnt, sif.locked);
        end
      end
      if (i == 8) begin
        total++;
        if (sif.locked !== 1'b1 || sif.err_cnt !== 8'd2) begin
          bad++; $display("FAIL miss_cleared: got l=%b ec=%0d want 1 2", sif.locked, sif.err_cnt);
        end
      end
    end
  endtask

  task automatic test_double_error();
    int seq[12] = '{3, 12, 34, 59, 233, 24, 77, 77, 1, 155, 0, 3};
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'(seq[i]));
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL double_err[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
      if (i == 7) begin
        total++;
        if (sif.err !== 1'b1 || sif.err_cnt !== 8'd4 || sif.locked !== 1'b0) begin
          bad++; $display("FAIL lock_loss: got err=%b ec=%0d l=%b want 1 4 0",
                          sif.err, sif.err_cnt, sif.locked);
        end
      end
      if (i == 10) begin
        total++;
        if (sif.locked !== 1'b0) begin bad++; $display("FAIL relock_early: got %b want 0", sif.locked); end
      end
    end
    total++;
    if (sif.locked !== 1'b1 || sif.expected !== 8'd12) begin
      bad++; $display("FAIL relock: got l=%b e=%0d want 1 12", sif.locked, sif.expected);
    end
  endtask

  task automatic test_valid_toggle();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(1'b0, 1'b1, 8'(tbl[m_pos]));
      else            step(1'b0, 1'b0, 8'd99);
      total++;
      if (dut_vec !== model_vec() || sif.err !== 1'b0) begin
        bad++; $display("FAIL valid_toggle[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_hunt_check();
    int seq[6] = '{7, 12, 34, 200, 3, 12};
    int exp_e[6] = '{3, 34, 59, 3, 12, 34};
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 8'(seq[i]));
      total++;
      if (sif.expected !== 8'(exp_e[i]) || sif.locked !== 1'b0 || sif.err !== 1'b0 ||
          sif.err_cnt !== 8'd0) begin
        bad++; $display("FAIL hunt_check[%0d]: got e=%0d l=%b err=%b ec=%0d want %0d 0 0 0",
                        i, sif.expected, sif.locked, sif.err, sif.err_cnt, exp_e[i]);
      end
    end
    step(1'b1, 1'b1, 8'(tbl[m_pos]));
    total++;
    if (dut_vec !== {1'b0, 1'b0, 8'd0, 8'd0, 8'd3}) begin
      bad++; $display("FAIL reset_in_check: got %h want %h", dut_vec, {1'b0, 1'b0, 8'd0, 8'd0, 8'd3});
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(tbl[i]));
      for (int i = 0; i < 2; i++) begin
        step(1'b0, 1'b1, bad_val());
        total++;
        if (dut_vec !== model_vec()) begin
          bad++; $display("FAIL saturation[%0d.%0d]: got %h want %h", n, i, dut_vec, model_vec());
        end
      end
    end
    total++;
    if (sif.err_cnt !== 8'd255 || sif.locked !== 1'b0) begin
      bad++; $display("FAIL err_sat: got ec=%0d l=%b want 255 0", sif.err_cnt, sif.locked);
    end
  endtask

  task automatic test_random();
    int gen = $urandom_range(0, 8);
    logic [7:0] d;
    bit v, r;
    step(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 599) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = 8'(tbl[gen]);
      if ($urandom_range(0, 19) == 0) d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 149) == 0) gen = $urandom_range(0, 8);
      if (v) gen = (gen + 1) % 9;
      step(r, v, d);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    sif.din_valid = 1'b0;
    sif.din = 8'd0;
    model_step(1'b1, 1'b0, 0);
    test_reset();
    test_lock_acquire();
    test_cycle_wrap();
    test_single_error();
    test_double_error();
    test_valid_toggle();
    test_hunt_check();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
